// File: rtl/reg_bus_endpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_endpoint_pkg
// Description : Register map constants, types and decode helpers shared by the
//               register bus endpoint and its sub-modules.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_endpoint_pkg;

    typedef logic [31:0] reg_data_t;

    localparam logic [7:0]  REG_EP_ID       = 8'h00;
    localparam logic [7:0]  REG_EP_CTRL     = 8'h04;
    localparam logic [7:0]  REG_EP_CFG_BASE = 8'h10;
    localparam logic [7:0]  REG_EP_CNT_BASE = 8'h40;
    localparam logic [7:0]  REG_EP_CNT_END  = 8'hC0;
    localparam logic [15:0] REG_EP_ID_MAGIC = 16'h5EB0;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    function automatic logic [3:0] reg_ep_cfg_idx(input logic [7:0] addr);
        return 4'((addr - REG_EP_CFG_BASE) >> 2);
    endfunction

    function automatic logic [3:0] reg_ep_cnt_idx(input logic [7:0] addr);
        return 4'((addr - REG_EP_CNT_BASE) >> 3);
    endfunction

    // n is the number of implemented registers; indices at or above it are unmapped
    function automatic logic reg_ep_is_cfg(input logic [7:0] addr, input logic [4:0] n);
        return (addr >= REG_EP_CFG_BASE) && (addr < REG_EP_CNT_BASE) &&
               (addr[1:0] == 2'b00) && ({1'b0, reg_ep_cfg_idx(addr)} < n);
    endfunction

    function automatic logic reg_ep_is_cnt(input logic [7:0] addr, input logic [4:0] n);
        return (addr >= REG_EP_CNT_BASE) && (addr < REG_EP_CNT_END) &&
               (addr[1:0] == 2'b00) && ({1'b0, reg_ep_cnt_idx(addr)} < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_endpoint_counter.sv
`default_nettype none
// ============================================================================
// Module      : reg_event_counter
// Description : 64-bit wrapping event counter with synchronous clear that
//               takes priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_event_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_clear,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/reg_bus_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_endpoint
// Description : Per-component register bus responder: ID/CTRL/config registers,
//               64-bit event counters with MSB snapshot, 2-cycle read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_endpoint
    import reg_bus_endpoint_pkg::*;
#(
    parameter int COMP_ID = 0,
    parameter int N_CFG   = 4,
    parameter int N_CNT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_bus_wvalid,
    input  logic [15:0]          reg_bus_waddr,
    input  logic [31:0]          reg_bus_wdata,
    input  logic                 reg_bus_arvalid,
    input  logic [15:0]          reg_bus_araddr,
    output logic                 reg_bus_rvalid,
    output reg_data_t            reg_bus_rdata,
    output logic [N_CFG*32-1:0]  cfg,
    output logic                 count_en,
    input  logic [N_CNT-1:0]     event_inc
);

    localparam logic [4:0]  C_N_CFG = 5'(N_CFG);
    localparam logic [4:0]  C_N_CNT = 5'(N_CNT);
    localparam logic [15:0] C_ID_LO = 16'(COMP_ID);

    logic [N_CFG*32-1:0] r_cfg;
    logic                r_count_en;
    logic [31:0]         r_shadow;
    logic                r_rd_v1;
    logic [7:0]          r_rd_addr1;
    logic                r_rvalid;
    reg_data_t           r_rdata;

    logic [7:0]  w_waddr;
    logic        w_wr_ctrl;
    logic        w_wr_cfg;
    logic [3:0]  w_wcfg_idx;
    logic        w_clear_all;
    logic [63:0] w_cnt [N_CNT];
    reg_data_t   w_rd_data;
    logic        w_snap;
    logic [31:0] w_snap_val;
    logic        w_unused;

    assign w_unused    = ^{reg_bus_waddr[15:8], reg_bus_araddr[15:8]};
    assign w_waddr     = reg_bus_waddr[7:0];
    assign w_wr_ctrl   = reg_bus_wvalid && (w_waddr == REG_EP_CTRL);
    assign w_wr_cfg    = reg_bus_wvalid && reg_ep_is_cfg(w_waddr, C_N_CFG);
    assign w_wcfg_idx  = reg_ep_cfg_idx(w_waddr);
    assign w_clear_all = w_wr_ctrl && reg_bus_wdata[CTRL_CLEAR_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg      <= '0;
            r_count_en <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_count_en <= reg_bus_wdata[CTRL_EN_BIT];
            end
            for (int i = 0; i < N_CFG; i++) begin
                if (w_wr_cfg && (w_wcfg_idx == 4'(i))) begin
                    r_cfg[i*32 +: 32] <= reg_bus_wdata;
                end
            end
        end
    end

    // Enable is registered, so a CTRL write takes effect on the following cycle
    generate
        for (genvar j = 0; j < N_CNT; j++) begin : g_cnt
            reg_event_counter u_cnt (
                .clk     (clk),
                .rst     (rst),
                .i_inc   (r_count_en & event_inc[j]),
                .i_clear (w_clear_all),
                .o_count (w_cnt[j])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data  = '0;
        w_snap     = 1'b0;
        w_snap_val = '0;
        if (r_rd_addr1 == REG_EP_ID) begin
            w_rd_data = {REG_EP_ID_MAGIC, C_ID_LO};
        end else if (r_rd_addr1 == REG_EP_CTRL) begin
            w_rd_data[CTRL_EN_BIT] = r_count_en;
        end else if (reg_ep_is_cfg(r_rd_addr1, C_N_CFG)) begin
            for (int i = 0; i < N_CFG; i++) begin
                if (reg_ep_cfg_idx(r_rd_addr1) == 4'(i)) begin
                    w_rd_data = r_cfg[i*32 +: 32];
                end
            end
        end else if (reg_ep_is_cnt(r_rd_addr1, C_N_CNT)) begin
            if (r_rd_addr1[2]) begin
                w_rd_data = r_shadow;
            end else begin
                for (int j = 0; j < N_CNT; j++) begin
                    if (reg_ep_cnt_idx(r_rd_addr1) == 4'(j)) begin
                        w_rd_data  = w_cnt[j][31:0];
                        w_snap_val = w_cnt[j][63:32];
                    end
                end
                w_snap = 1'b1;
            end
        end
    end

    // Stage 1 latches the address; stage 2 muxes live state and snapshots the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_addr1 <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_shadow   <= '0;
        end else begin
            r_rd_v1  <= reg_bus_arvalid;
            r_rvalid <= r_rd_v1;
            if (reg_bus_arvalid) begin
                r_rd_addr1 <= reg_bus_araddr[7:0];
            end
            if (r_rd_v1) begin
                r_rdata <= w_rd_data;
                if (w_snap) begin
                    r_shadow <= w_snap_val;
                end
            end
        end
    end

    assign reg_bus_rvalid = r_rvalid;
    assign reg_bus_rdata  = r_rdata;
    assign cfg            = r_cfg;
    assign count_en       = r_count_en;

endmodule
`default_nettype wire

// File: doc/reg_bus_endpoint.md
Name: reg_bus_endpoint

Overview:
- Per-component responder for the tile register bus driven by the OCL slave: consumes this component's reg_bus write strobe and read request, and returns read data with fixed latency.
- Hosts a bank of host-writable config registers, a control register and 64-bit event counters with consistent MSB/LSB snapshot reads.
- Instantiated once inside each core, coalescer, splitter and queue, replacing ad-hoc per-component register decode.

Parameters:
- COMP_ID, 0, component index on reg bus; returned by the ID register.
- N_CFG, 4, number of 32-bit config registers (1..12).
- N_CNT, 4, number of 64-bit event counters (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reg_bus_wvalid  in  1  write strobe for this component
- reg_bus_waddr  in  16  write address; only [7:0] decoded
- reg_bus_wdata  in  32  write data
- reg_bus_arvalid  in  1  read request for this component
- reg_bus_araddr  in  16  read address; only [7:0] decoded
- reg_bus_rvalid  out  1  read response valid, one-cycle pulse
- reg_bus_rdata  out  32  read response data (reg_data_t)
- cfg  out  N_CFG*32  config register contents, cfg[i] at [32i +: 32]
- count_en  out  1  CTRL bit 0
- event_inc  in  N_CNT  per-counter increment strobes

Behaviour:
- Reset, asynchronous: rvalid=0, rdata=0, cfg=0, count_en=0, all counters 0, MSB shadow 0, read pipeline empty.
- Register map, addr[7:0]:
  - 0x00 ID, RO: {16'h5EB0, COMP_ID[15:0]}.
  - 0x04 CTRL: bit0 count_en (R/W); bit1 clear-all, write-1 pulse, reads 0.
  - 0x10+4i cfg[i], R/W.
  - 0x40+8j counter j LSB, RO.
  - 0x44+8j counter j MSB shadow, RO.
- Writes: no backpressure. Committed at the edge ending the cycle in which wvalid is high. Writes to RO or unmapped addresses are ignored.
- Counters: 64-bit, wrap modulo 2^64. Increment by 1 when count_en && event_inc[j].
  - A clear-all write zeroes all counters at the same edge.
  - Clear beats increment in the same cycle.
  - Writing count_en=0 stops counting from the next cycle.
- Reads, fixed 2-cycle pipeline: arvalid in cycle T gives rvalid in cycle T+2 only.
  - Stage 1 registers the address at end of T.
  - During T+1 the data is muxed from current state, so a write in cycle T or earlier is visible and a write in T+1 is not.
  - Counter values include events through cycle T.
- Back-to-back arvalid every cycle is supported; responses stay in order with one rvalid per request.
- Snapshot: a read of counter j LSB copies counter j [63:32] into a single shared MSB shadow at the same edge the LSB data is selected. A later MSB read of any counter returns the shadow, giving torn-free 64-bit reads.
  - Reading the MSB address without a prior LSB read returns the stale shadow. This is intended.
- Unmapped read addresses, including cfg index >= N_CFG and counter index >= N_CNT: rvalid still pulses, rdata=32'h0.
- rdata holds its last value when rvalid=0.
- Simultaneous wvalid and arvalid to the same address in cycle T: the read returns the new value.
- Reset asserted mid-read: the in-flight response is dropped, and no rvalid appears after reset deasserts.

Decomposition:
- Shared package, in the existing swarm package: REG_EP_ID=8'h00, REG_EP_CTRL=8'h04, REG_EP_CFG_BASE=8'h10, REG_EP_CNT_BASE=8'h40, REG_EP_ID_MAGIC=16'h5EB0, CTRL bit-position constants.
- One sub-module: reg_event_counter. It is the 64-bit counter with inc/clear, instantiated N_CNT times via generate.
- Decode and read pipeline stay in reg_bus_endpoint.

Test Plan:
- Reset, then arvalid addr 0x00 at T with COMP_ID=5 -> rvalid only at T+2, rdata=32'h5EB0_0005; rvalid low at T+1 and T+3.
- Write 0x10 <= 32'hCAFE_0001, then read 0x10 in the same cycle as the write -> cfg[0]=32'hCAFE_0001 next cycle, read returns 32'hCAFE_0001. Write 0x00 <= 1 -> ID read unchanged.
- Write CTRL=1, pulse event_inc[2] for 7 cycles, read 0x50 then 0x54 -> 7 then 0. Preload counter to 0xFFFF_FFFF, 1 event, read LSB -> 0; MSB -> 1.
- LSB read of counter 0 at T while events continue, MSB read at T+5 -> MSB equals value captured at T+1, not the live value.
- Write CTRL=3 in the same cycle as event_inc[0]=1 -> counter 0 reads 0, count_en=1 afterwards; CTRL reads 1.
- arvalid on 3 consecutive cycles to 0x00, 0x10, 0xFC -> 3 consecutive rvalid pulses with ID, cfg[0], 0 in order. Assert rst during the second -> no rvalid after reset, all outputs 0.
